nios2_ocimem_ctrl: RTL and testbench
====================================

Name: nios2_ocimem_ctrl

Overview:
- Debug-memory controller directly downstream of the debug module's sysclk stage.
- Consumes jdo and the ocimem take_action strobes, and executes the resulting JTAG reads and writes on a small on-chip debug RAM (monitor/OCI RAM).
- Returns MonDReg, monitor_ready and monitor_error to the TCK side.
- Also arbitrates a CPU-side Avalon-MM debug slave port onto the same RAM.

Parameters:
- ADDR_W, 8, word-address width of the debug RAM (depth 2**ADDR_W x 32); legal range 4..16.
- INIT_FILE, "", optional RAM init file; empty means no init.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- jdo  in  38  JTAG data captured by the sysclk stage.
- take_action_ocimem_a  in  1  1-cycle strobe: load address / command.
- take_action_ocimem_b  in  1  1-cycle strobe: write jdo data.
- take_no_action_ocimem_a  in  1  1-cycle strobe: streaming read.
- MonDReg  out  32  monitor data register.
- monitor_ready  out  1  last JTAG command complete.
- monitor_error  out  1  sticky JTAG overrun/protection error.
- avs_address  in  ADDR_W  CPU word address.
- avs_read  in  1  CPU read request.
- avs_write  in  1  CPU write request.
- avs_writedata  in  32  CPU write data.
- avs_byteenable  in  4  CPU byte enables.
- avs_readdata  out  32  CPU read data.
- avs_waitrequest  out  1  CPU stall.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low: reset_n low clears all state immediately; release is used synchronously.
- Reset values: MonDReg=0, MonAReg=0, monitor_ready=1, monitor_error=0, avs_readdata=0, FSM=IDLE, pending flags=0. RAM contents are not cleared.
- jdo field decode:
  - ocimem_a: address = jdo[17 +: ADDR_W]; read flag = jdo[35]; error-clear = jdo[36].
  - ocimem_b: write data = jdo[34:3].
- Strobe handling:
  - ocimem_a:
    - MonAReg <= address.
    - If jdo[36]=1, clear monitor_error.
    - If jdo[35]=1, set jrd_pend.
    - monitor_ready <= 0 only if a read is requested.
  - take_no_action_ocimem_a: set jrd_pend and clear monitor_ready.
  - ocimem_b: MonDReg <= jdo[34:3]; set jwr_pend; clear monitor_ready.
- Overrun: a read or write strobe arriving while jrd_pend or jwr_pend is already set is dropped. The address load still happens. monitor_error <= 1.
- Multiple strobes in one cycle: ocimem_a has priority; the others count as overrun.
- FSM states: IDLE, JRD, JRD_CAP, JWR, CRD, CRD_CAP, CWR.
- IDLE priority: jwr_pend, then jrd_pend, then avs_write, then avs_read.
  - JTAG always wins; the CPU is never served while a JTAG flag is pending at IDLE.
- JRD sequence:
  - JRD: RAM address = MonAReg (synchronous RAM, 1-cycle read latency).
  - JRD_CAP: MonDReg <= q; MonAReg <= MonAReg+1 (mod 2**ADDR_W); clear jrd_pend; monitor_ready <= 1; go to IDLE.
- JWR sequence: write MonDReg to MonAReg with all bytes enabled; MonAReg <= MonAReg+1; clear jwr_pend; monitor_ready <= 1; go to IDLE.
- JTAG latency with the FSM idle: strobe at cycle N → MonDReg and monitor_ready valid at N+4 for a read, N+3 for a write.
- CPU read: CRD (address = avs_address) → CRD_CAP (avs_readdata <= q; waitrequest low this cycle) → IDLE.
- CPU write: CWR writes avs_writedata with avs_byteenable; waitrequest low this cycle; → IDLE.
- avs_waitrequest = (avs_read | avs_write) & ~(state==CRD_CAP | state==CWR). It is 0 when there is no request.
- Read and write asserted together: the write is served; the read stays stalled.
- Address wrap: increment of 2**ADDR_W-1 gives 0.
- CPU behaviour: address and data must stay stable while waitrequest is high. A dropped request mid-transaction completes harmlessly.
- Reset mid-operation: the in-flight access is aborted. No partial write: the RAM write enable is combinational from the state and is deasserted by reset.

Optional Feature:
- Macro: OCIMEM_WRITE_PROTECT_EN.
- When defined:
  - Adds input debug_wp (1 bit).
  - A JTAG write is suppressed when debug_wp=1 and MonAReg[ADDR_W-1]=1.
  - Suppressed write: no RAM write, monitor_error <= 1, MonAReg still increments, monitor_ready still set.
  - CPU writes are unaffected.
- When undefined: no debug_wp port; all JTAG writes are performed.

Test Plan:
- Reset, then CPU write 0xDEADBEEF to address 0x10 with byteenable 0xF. Then ocimem_a with jdo address=0x10 and jdo[35]=1. Required: MonDReg=0xDEADBEEF and monitor_ready=1 at strobe+4; MonAReg=0x11.
- ocimem_a to address 0xFF with no read, then two ocimem_b strobes of 0x1 and 0x2 spaced 5 cycles apart. Required: RAM[0xFF]=1, RAM[0x00]=2 (wrap), MonAReg=0x01.
- ocimem_b followed by take_no_action_ocimem_a one cycle later. Required: the read is dropped, monitor_error=1, the write completes. A subsequent ocimem_a with jdo[36]=1 clears monitor_error to 0.
- avs_read held at address 0x05 while jwr_pend is set. Required: the JTAG write executes first; waitrequest stays high until CRD_CAP; readdata reflects the new value if the address matches.
- CPU write with byteenable 0x3 of 0xAABBCCDD over 0x11223344. Required: a read returns 0x1122CCDD.
- With OCIMEM_WRITE_PROTECT_EN and debug_wp=1, a JTAG write to address 0x80. Required: RAM unchanged, monitor_error=1, MonAReg=0x81.

Source files
------------

// File: rtl/nios2_ocimem_ctrl.sv
// ---------------------------------------------------------------------------
// nios2_ocimem_ctrl
//
// Debug-memory controller that sits directly after the debug module's sysclk
// stage. It turns the ocimem take_action strobes and the captured jdo word
// into reads and writes on a small on-chip monitor/OCI RAM. It returns
// MonDReg, monitor_ready and monitor_error to the TCK side. It also serves a
// CPU-side Avalon-MM debug slave port from the same RAM. When a JTAG request
// is pending, the JTAG side is always served before the CPU.
//
// Parameters:
//   ADDR_W    word-address width of the RAM (depth 2**ADDR_W x 32), 4..16
//   INIT_FILE preload image path for the memory-compiler flow; this RTL
//             does not read it, and RAM contents start undefined
//
// Optional feature (macro OCIMEM_WRITE_PROTECT_EN):
//   Adds input debug_wp. A JTAG write is suppressed when debug_wp is high
//   and MonAReg targets the upper half of the RAM. A suppressed write raises
//   monitor_error, still advances MonAReg and still sets monitor_ready.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   jdo[37:0]                     JTAG data from the sysclk stage
//   take_action_ocimem_a          load address / command (read flag, err clear)
//   take_action_ocimem_b          write jdo[34:3] to MonAReg
//   take_no_action_ocimem_a       streaming read at MonAReg
//   MonDReg, monitor_ready,
//   monitor_error                 results returned to the TCK side
//   avs_*                         CPU Avalon-MM slave port (word addressed)
//   debug_wp                      write-protect input (optional feature only)
// ---------------------------------------------------------------------------
module nios2_ocimem_ctrl #(
    parameter int ADDR_W    = 8,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
`ifdef OCIMEM_WRITE_PROTECT_EN
    input  logic              debug_wp,
`endif
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        JRD,
        JRD_CAP,
        JWR,
        CRD,
        CRD_CAP,
        CWR
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   MonAReg;
    logic                jrd_pend;
    logic                jwr_pend;

    logic [31:0]         mem [0:DEPTH-1];
    logic [31:0]         ram_q;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [31:0]         ram_wdata;
    logic [3:0]          ram_be;
    logic [ADDR_W-1:0]   ram_raddr;

    logic [ADDR_W-1:0]   jdo_addr;
    logic                jtag_busy;
    logic                jwr_blocked;
    logic                unused_jdo_bits;

    assign jdo_addr        = jdo[17 +: ADDR_W];
    assign jtag_busy       = jrd_pend | jwr_pend;
    assign unused_jdo_bits = ^{jdo[37], jdo[2:0]};

    // The write-protect check looks at the MSB of the JTAG address, so the
    // upper half of the RAM is the protected region.
`ifdef OCIMEM_WRITE_PROTECT_EN
    assign jwr_blocked = debug_wp & MonAReg[ADDR_W-1];
`else
    assign jwr_blocked = 1'b0;
`endif

    // The CPU is released only in the cycle its access actually hits the
    // RAM. When there is no request, the port is never stalled.
    assign avs_waitrequest = (avs_read | avs_write) &
                             ~((state == CRD_CAP) | (state == CWR));

    // The write port is decoded purely from the state. Reset forces IDLE,
    // which drops the write enable at once, so an aborted access cannot
    // leave a partial write behind.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = MonAReg;
        ram_wdata = MonDReg;
        ram_be    = 4'hF;
        if (state == JWR) begin
            ram_we = ~jwr_blocked;
        end else if (state == CWR) begin
            ram_we    = 1'b1;
            ram_waddr = avs_address;
            ram_wdata = avs_writedata;
            ram_be    = avs_byteenable;
        end
    end

    // The read address follows MonAReg only while a JTAG read is being
    // issued. Otherwise it tracks the CPU address, which is held stable
    // through CRD.
    assign ram_raddr = (state == JRD) ? MonAReg : avs_address;

    // Synchronous single-port-style RAM with byte-lane writes and a
    // one-cycle read latency. It has no reset, so contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we && ram_be[i]) begin
                mem[ram_waddr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
        ram_q <= mem[ram_raddr];
    end

    // Main controller: the access FSM, followed by JTAG strobe capture.
    // Strobe handling comes after the FSM in this block so that an address
    // load from ocimem_a overrides the post-access MonAReg increment in the
    // same cycle. A strobe that arrives while a JTAG access is still pending
    // is dropped and flagged as an overrun. An error raised by a protected
    // write wins over an error-clear command in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            MonAReg       <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
            avs_readdata  <= '0;
            jrd_pend      <= 1'b0;
            jwr_pend      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (jwr_pend) begin
                        state <= JWR;
                    end else if (jrd_pend) begin
                        state <= JRD;
                    end else if (avs_write) begin
                        state <= CWR;
                    end else if (avs_read) begin
                        state <= CRD;
                    end
                end
                JRD: begin
                    state <= JRD_CAP;
                end
                JRD_CAP: begin
                    MonDReg       <= ram_q;
                    MonAReg       <= MonAReg + ADDR_W'(1);
                    jrd_pend      <= 1'b0;
                    monitor_ready <= 1'b1;
                    state         <= IDLE;
                end
                JWR: begin
                    if (jwr_blocked) begin
                        monitor_error <= 1'b1;
                    end
                    MonAReg       <= MonAReg + ADDR_W'(1);
                    jwr_pend      <= 1'b0;
                    monitor_ready <= 1'b1;
                    state         <= IDLE;
                end
                CRD: begin
                    state <= CRD_CAP;
                end
                CRD_CAP: begin
                    avs_readdata <= ram_q;
                    state        <= IDLE;
                end
                CWR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (take_action_ocimem_a) begin
                MonAReg <= jdo_addr;
                if (jdo[36] && !((state == JWR) && jwr_blocked)) begin
                    monitor_error <= 1'b0;
                end
                if (jdo[35]) begin
                    if (jtag_busy) begin
                        monitor_error <= 1'b1;
                    end else begin
                        jrd_pend      <= 1'b1;
                        monitor_ready <= 1'b0;
                    end
                end
                if (take_action_ocimem_b || take_no_action_ocimem_a) begin
                    monitor_error <= 1'b1;
                end
            end else if (take_action_ocimem_b) begin
                if (jtag_busy) begin
                    monitor_error <= 1'b1;
                end else begin
                    MonDReg       <= jdo[34:3];
                    jwr_pend      <= 1'b1;
                    monitor_ready <= 1'b0;
                end
                if (take_no_action_ocimem_a) begin
                    monitor_error <= 1'b1;
                end
            end else if (take_no_action_ocimem_a) begin
                if (jtag_busy) begin
                    monitor_error <= 1'b1;
                end else begin
                    jrd_pend      <= 1'b1;
                    monitor_ready <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_nios2_ocimem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nios2_ocimem_ctrl
//
// Testbench for nios2_ocimem_ctrl, built with ADDR_W = 8. It keeps a
// behavioural reference model: a word array of the RAM, plus the expected
// JTAG address register, data register and error flag. Directed steps come
// first, followed by a randomized mix of CPU and JTAG operations. Every
// operation runs to completion before the next one starts. When
// OCIMEM_WRITE_PROTECT_EN is defined, the bench also drives debug_wp.
// ---------------------------------------------------------------------------
module tb_nios2_ocimem_ctrl;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;
    localparam int LIMIT = 50;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [37:0]   jdo;
    logic          take_action_ocimem_a;
    logic          take_action_ocimem_b;
    logic          take_no_action_ocimem_a;
`ifdef OCIMEM_WRITE_PROTECT_EN
    logic          debug_wp;
`endif
    logic [31:0]   MonDReg;
    logic          monitor_ready;
    logic          monitor_error;
    logic [AW-1:0] avs_address;
    logic          avs_read;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic [3:0]    avs_byteenable;
    logic [31:0]   avs_readdata;
    logic          avs_waitrequest;

    int            checks   = 0;
    int            failures = 0;

    logic [31:0]   ram_model [DEPTH];
    logic [AW-1:0] areg_model;
    logic          err_model;
    logic          wp_model;
    logic [31:0]   rd;
    logic [31:0]   d;
    int            st;
    int            op;

    nios2_ocimem_ctrl #(.ADDR_W(AW)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
`ifdef OCIMEM_WRITE_PROTECT_EN
        .debug_wp                (debug_wp),
`endif
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (nw & m) | (old & ~m);
    endfunction

    function automatic logic [37:0] mk_a(input logic [AW-1:0] addr, input logic rdf, input logic clr);
        logic [37:0] j;
        j = 38'({$urandom(), $urandom()});
        j[17 +: AW] = addr;
        j[35] = rdf;
        j[36] = clr;
        return j;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] data);
        logic [37:0] j;
        j = 38'({$urandom(), $urandom()});
        j[34:3] = data;
        return j;
    endfunction

    // Drives one cycle of strobes. The task returns 1 time unit after the
    // capturing edge.
    task automatic applyStimulus(input logic [37:0] j, input logic a, input logic b, input logic na);
        jdo = j;
        take_action_ocimem_a = a;
        take_action_ocimem_b = b;
        take_no_action_ocimem_a = na;
        tick();
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        jdo = 38'({$urandom(), $urandom()});
    endtask

    task automatic cpu_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] be, output int stalls);
        avs_address = addr;
        avs_writedata = data;
        avs_byteenable = be;
        avs_write = 1'b1;
        stalls = 0;
        @(negedge clk);
        while (avs_waitrequest !== 1'b0 && stalls < LIMIT) begin
            stalls++;
            @(negedge clk);
        end
        checkOutput("cpu_write handshake", 32'(stalls < LIMIT), 32'd1);
        @(posedge clk);
        #1;
        avs_write = 1'b0;
        ram_model[addr] = merge(ram_model[addr], data, be);
    endtask

    task automatic cpu_read(input logic [AW-1:0] addr, output logic [31:0] data, output int stalls);
        avs_address = addr;
        avs_read = 1'b1;
        stalls = 0;
        @(negedge clk);
        while (avs_waitrequest !== 1'b0 && stalls < LIMIT) begin
            stalls++;
            @(negedge clk);
        end
        checkOutput("cpu_read handshake", 32'(stalls < LIMIT), 32'd1);
        @(posedge clk);
        #1;
        avs_read = 1'b0;
        data = avs_readdata;
    endtask

    task automatic jtag_load(input logic [AW-1:0] addr, input logic clr);
        applyStimulus(mk_a(addr, 1'b0, clr), 1'b1, 1'b0, 1'b0);
        areg_model = addr;
        if (clr) err_model = 1'b0;
        checkOutput("load ready", 32'(monitor_ready), 32'd1);
        checkOutput("load error", 32'(monitor_error), 32'(err_model));
    endtask

    task automatic jtag_read(input logic [AW-1:0] addr, input string tag);
        applyStimulus(mk_a(addr, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0);
        checkOutput({tag, " ready low"}, 32'(monitor_ready), 32'd0);
        tick();
        tick();
        checkOutput({tag, " ready low before data"}, 32'(monitor_ready), 32'd0);
        tick();
        checkOutput({tag, " data"}, MonDReg, ram_model[addr]);
        checkOutput({tag, " ready"}, 32'(monitor_ready), 32'd1);
        areg_model = addr + AW'(1);
    endtask

    task automatic jtag_stream(input string tag);
        applyStimulus(mk_b(32'h0), 1'b0, 1'b0, 1'b1);
        checkOutput({tag, " ready low"}, 32'(monitor_ready), 32'd0);
        tick();
        tick();
        tick();
        checkOutput({tag, " data"}, MonDReg, ram_model[areg_model]);
        checkOutput({tag, " ready"}, 32'(monitor_ready), 32'd1);
        areg_model = areg_model + AW'(1);
    endtask

    task automatic jtag_write(input logic [31:0] data, input string tag);
        applyStimulus(mk_b(data), 1'b0, 1'b1, 1'b0);
        checkOutput({tag, " ready low"}, 32'(monitor_ready), 32'd0);
        checkOutput({tag, " MonDReg"}, MonDReg, data);
        tick();
        tick();
        checkOutput({tag, " ready"}, 32'(monitor_ready), 32'd1);
        if (wp_model && areg_model[AW-1]) err_model = 1'b1;
        else ram_model[areg_model] = data;
        areg_model = areg_model + AW'(1);
        checkOutput({tag, " error"}, 32'(monitor_error), 32'(err_model));
    endtask

    initial begin
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
`ifdef OCIMEM_WRITE_PROTECT_EN
        debug_wp = 1'b0;
`endif
        wp_model = 1'b0;
        err_model = 1'b0;
        areg_model = '0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        avs_byteenable = '0;

        // Reset state.
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        checkOutput("reset MonDReg", MonDReg, 32'h0);
        checkOutput("reset ready", 32'(monitor_ready), 32'd1);
        checkOutput("reset error", 32'(monitor_error), 32'd0);
        checkOutput("reset readdata", avs_readdata, 32'h0);
        checkOutput("reset waitrequest", 32'(avs_waitrequest), 32'd0);
        checkOutput("reset MonAReg", 32'(dut.MonAReg), 32'h0);

        // Give the whole RAM known random contents through the CPU port.
        for (int i = 0; i < DEPTH; i++) cpu_write(AW'(i), $urandom(), 4'hF, st);

        // A CPU write is followed by a JTAG read of the same word.
        cpu_write(8'h10, 32'hDEADBEEF, 4'hF, st);
        checkOutput("cpu write stalls", 32'(st), 32'd1);
        jtag_read(8'h10, "jrd 0x10");
        checkOutput("jrd 0x10 value", MonDReg, 32'hDEADBEEF);
        checkOutput("jrd MonAReg", 32'(dut.MonAReg), 32'h11);

        // Two JTAG writes starting at the top address wrap around to 0.
        jtag_load(8'hFF, 1'b0);
        jtag_write(32'h1, "jwr 0xFF");
        repeat (3) tick();
        jtag_write(32'h2, "jwr wrap");
        checkOutput("wrap MonAReg", 32'(dut.MonAReg), 32'h01);
        cpu_read(8'hFF, rd, st);
        checkOutput("ram 0xFF", rd, 32'h1);
        checkOutput("cpu read stalls", 32'(st), 32'd2);
        cpu_read(8'h00, rd, st);
        checkOutput("ram 0x00", rd, 32'h2);

        // A streaming read issued one cycle after a write is an overrun.
        jtag_load(8'h20, 1'b0);
        d = $urandom();
        applyStimulus(mk_b(d), 1'b0, 1'b1, 1'b0);
        applyStimulus(mk_b(32'h0), 1'b0, 1'b0, 1'b1);
        checkOutput("overrun error", 32'(monitor_error), 32'd1);
        tick();
        checkOutput("overrun write ready", 32'(monitor_ready), 32'd1);
        ram_model[8'h20] = d;
        areg_model = 8'h21;
        err_model = 1'b1;
        repeat (4) tick();
        checkOutput("dropped read MonAReg", 32'(dut.MonAReg), 32'h21);
        checkOutput("dropped read MonDReg", MonDReg, d);
        cpu_read(8'h20, rd, st);
        checkOutput("overrun write data", rd, d);
        jtag_load(8'h30, 1'b1);
        checkOutput("error cleared", 32'(monitor_error), 32'd0);

        // A CPU read waits behind a pending JTAG write to the same word.
        jtag_load(8'h05, 1'b0);
        d = $urandom();
        applyStimulus(mk_b(d), 1'b0, 1'b1, 1'b0);
        ram_model[8'h05] = d;
        areg_model = 8'h06;
        cpu_read(8'h05, rd, st);
        checkOutput("cpu read after jwr stalls", 32'(st), 32'd4);
        checkOutput("cpu read after jwr data", rd, d);

        // Byte-enable merge.
        cpu_write(8'h40, 32'h11223344, 4'hF, st);
        cpu_write(8'h40, 32'hAABBCCDD, 4'h3, st);
        cpu_read(8'h40, rd, st);
        checkOutput("byteenable merge", rd, 32'h1122CCDD);

        // With read and write both asserted, the write is served and the
        // read stays stalled.
        avs_address = 8'h41;
        avs_writedata = 32'h5A5A0F0F;
        avs_byteenable = 4'hF;
        avs_read = 1'b1;
        avs_write = 1'b1;
        st = 0;
        @(negedge clk);
        while (avs_waitrequest !== 1'b0 && st < LIMIT) begin
            st++;
            @(negedge clk);
        end
        checkOutput("rw both write first", 32'(st), 32'd1);
        @(posedge clk);
        #1;
        avs_write = 1'b0;
        ram_model[8'h41] = 32'h5A5A0F0F;
        @(negedge clk);
        checkOutput("rw both read stalled", 32'(avs_waitrequest), 32'd1);
        avs_read = 1'b0;
        tick();
        tick();
        cpu_read(8'h41, rd, st);
        checkOutput("rw both data", rd, 32'h5A5A0F0F);

`ifdef OCIMEM_WRITE_PROTECT_EN
        // A protected JTAG write is suppressed.
        wp_model = 1'b1;
        debug_wp = 1'b1;
        jtag_load(8'h80, 1'b0);
        jtag_write(32'hCAFEF00D, "jwr protected");
        checkOutput("wp error", 32'(monitor_error), 32'd1);
        checkOutput("wp MonAReg", 32'(dut.MonAReg), 32'h81);
        cpu_read(8'h80, rd, st);
        checkOutput("wp ram unchanged", rd, ram_model[8'h80]);
        jtag_load(8'h00, 1'b1);
        wp_model = 1'b0;
        debug_wp = 1'b0;
`endif

        // Randomized operation mix checked against the model.
        for (int k = 0; k < 60; k++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: cpu_write(AW'($urandom()), $urandom(), 4'($urandom_range(1, 15)), st);
                1: begin
                    avs_address = AW'($urandom());
                    cpu_read(avs_address, rd, st);
                    checkOutput("rand cpu read", rd, ram_model[avs_address]);
                end
                2: jtag_read(AW'($urandom()), "rand jrd");
                3: begin
`ifdef OCIMEM_WRITE_PROTECT_EN
                    wp_model = 1'($urandom_range(0, 1));
                    debug_wp = wp_model;
`endif
                    jtag_load(AW'($urandom()), 1'b0);
                    jtag_write($urandom(), "rand jwr");
                end
                default: jtag_stream("rand stream");
            endcase
            checkOutput("rand error", 32'(monitor_error), 32'(err_model));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
